debounce_fsm: RTL and testbench

//  Debounces a raw mechanical switch/button input and produces a clean level plus a
//  one-cycle rising-edge pulse. Sits directly upstream of the edge-detector stage.
//  db_level feeds that stage's level input. db_tick serves consumers that need the

---
 rtl/debounce_fsm.sv | 111 +++++++++++
 tb/tb_debounce_fsm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/debounce_fsm.sv
// Switch debouncer: 2-flop synchronizer feeding a four-state FSM with an N-bit
// stability counter; produces a clean level and a one-cycle rising-edge tick.
module debounce_fsm #(
  parameter int unsigned N = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         s1_q, s_sync_q;
  logic         level_q, level_d;
  logic         tick_q, tick_d;

  // Synchronize the raw switch into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s_sync_q <= 1'b0;
    end else begin
      s1_q     <= sw;
      s_sync_q <= s1_q;
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ZERO;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state and counter logic; a disagreeing input always beats an expired count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (s_sync_q) begin
          state_d = WAIT1;
          cnt_d   = CNT_MAX;
        end else begin
          state_d = ZERO;
        end
      end
      WAIT1: begin
        if (!s_sync_q) begin
          state_d = ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ONE: begin
        if (!s_sync_q) begin
          state_d = WAIT0;
          cnt_d   = CNT_MAX;
        end else begin
          state_d = ONE;
        end
      end
      WAIT0: begin
        if (s_sync_q) begin
          state_d = ONE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode, so they track state_q exactly.
  always_comb begin
    level_d = (state_d == ONE) || (state_d == WAIT0);
    tick_d  = (state_q == WAIT1) && (state_d == ONE);
  end

  assign db_level = level_q;
  assign db_tick  = tick_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm (N=3): directed scenarios plus random
// switch activity, compared every cycle against a run-length reference model.
module tb_debounce_fsm;

  localparam int unsigned N = 3;
  localparam int STABLE = 1 << N;

  logic clk;
  logic reset_n;
  logic sw;
  logic db_level;
  logic db_tick;

  int n_checks;
  int n_pass;

  // Reference model state: two-stage sample history, current level, run length.
  logic m_s1, m_s2, m_level, m_tick;
  int   m_run;

  debounce_fsm #(.N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_tick = 1'b0; m_run = 0;
  endtask

  // The FSM sees the sample taken two edges earlier. The level flips once the
  // seen value has disagreed with it for 2^N+1 consecutive edges.
  task automatic model_step(input logic v);
    logic seen;
    if (!reset_n) begin
      model_reset();
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = v;
      m_tick = 1'b0;
      if (seen != m_level) begin
        m_run++;
        if (m_run == STABLE + 1) begin
          m_level = seen;
          m_tick  = seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic cycle(input logic v);
    sw = v;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    check_eq("level", db_level, m_level);
    check_eq("tick", db_tick, m_tick);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) cycle(v);
  endtask

  // Counts edges from the first sample of v until db_level follows; expects 2+2^N.
  task automatic edge_latency(input string tag, input logic v);
    int first;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(v);
      if (first < 0 && db_level == v) first = i;
    end
    check_eq(tag, first, STABLE + 2);
  endtask

  int ticks;
  logic min_level;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    sw      = 1'b1;
    reset_n = 1'b0;

    // Reset held with switch high.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      check_eq("rst_level", db_level, 0);
    end
    reset_n = 1'b1;
    hold(1'b1, 5);
    // Asynchronous reset in the middle of WAIT1.
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_eq("rst_async_level", db_level, 0);
    check_eq("rst_async_tick", db_tick, 0);
    @(negedge clk);
    reset_n = 1'b1;
    hold(1'b0, 4);

    // Clean press, then tick width.
    edge_latency("press_latency", 1'b1);

    // Clean release, no tick expected (model checks every cycle).
    edge_latency("release_latency", 1'b0);

    // Bounce on press: 5 high, 2 low, then held high.
    hold(1'b1, 5);
    hold(1'b0, 2);
    check_eq("bounce_level", db_level, 0);
    edge_latency("bounce_latency", 1'b1);

    // Short low glitch while in ONE must leave the level alone.
    min_level = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cycle(i < 3 ? 1'b0 : 1'b1);
      min_level = min_level & db_level;
    end
    check_eq("glitch_level", min_level, 1);
    hold(1'b0, 12);

    // Input disagrees exactly when the count expires in WAIT1.
    hold(1'b1, STABLE);
    cycle(1'b0);
    hold(1'b0, 2);
    check_eq("boundary_level", db_level, 0);
    edge_latency("boundary_relatency", 1'b1);
    hold(1'b0, 12);

    // Four clean press/release pairs.
    ticks = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 14; i++) begin
        cycle(1'b1);
        if (db_tick) ticks++;
      end
      for (int i = 0; i < 14; i++) begin
        cycle(1'b0);
        if (db_tick) ticks++;
      end
    end
    check_eq("press_count", ticks, 4);

    // Random runs of bouncy activity.
    for (int s = 0; s < 60; s++) begin
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
